// File: rtl/ahb_bridge_ctrl.sv
// AHB-Lite slave front end for the AHB->APB bridge: turns single 32-bit transfers
// into request packets, stalls on bridge backpressure and waits for read responses.
module ahb_bridge_ctrl #(
  parameter int unsigned ADDR_LSB = 2,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        HCLK,
  input  logic        RESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [40:0] Packet_IN,
  output logic        H_Valid,
  input  logic        Bridge_Ready,
  input  logic [31:0] Bridge_Rd_Data,
  input  logic        Bridge_Rd_Valid,
  output logic        late_rsp
);

  localparam int unsigned PKT_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE, WR, RD_REQ, RD_WAIT, RD_DONE, ERR1, ERR2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PKT_ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;
  logic                  acc_c;
  logic                  size_ok_c;
  logic                  final_c;
  logic                  unused_c;

  assign acc_c     = HSEL & HTRANS[1] & HREADY;
  assign size_ok_c = (HSIZE == 3'b010);
  assign unused_c  = ^{HADDR, HTRANS[0]};

  // Output decode and next state; a final cycle may accept the next address phase.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    H_Valid   = 1'b0;
    Packet_IN = '0;
    final_c   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: final_c = 1'b1;
      WR: begin
        Packet_IN = {1'b1, addr_q, HWDATA};
        if (Bridge_Ready) begin
          H_Valid = 1'b1;
          final_c = 1'b1;
        end else begin
          HREADYOUT = 1'b0;
        end
      end
      RD_REQ: begin
        Packet_IN = {1'b0, addr_q, 32'h0};
        HREADYOUT = 1'b0;
        if (Bridge_Ready) begin
          H_Valid   = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        HREADYOUT = 1'b0;
        if (Bridge_Rd_Valid) state_nxt = RD_DONE;
        else if (cnt == CNT_W'(TIMEOUT - 1)) state_nxt = ERR1;
      end
      RD_DONE: final_c = 1'b1;
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: begin
        HRESP   = 1'b1;
        final_c = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (final_c) begin
      if (!acc_c)          state_nxt = IDLE;
      else if (!size_ok_c) state_nxt = ERR1;
      else if (HWRITE)     state_nxt = WR;
      else                 state_nxt = RD_REQ;
    end
  end

  // State, latched address, timeout counter, read data and sticky late-response flag.
  always_ff @(posedge HCLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      HRDATA   <= '0;
      late_rsp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (final_c && acc_c) addr_q <= HADDR[ADDR_LSB +: PKT_ADDR_W];
      if (state == RD_REQ)       cnt <= '0;
      else if (state == RD_WAIT) cnt <= cnt + CNT_W'(1);
      if (Bridge_Rd_Valid) begin
        if (state == RD_WAIT) HRDATA <= Bridge_Rd_Data;
        else                  late_rsp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bridge_ctrl.sv
// Directed bench for ahb_bridge_ctrl: a cycle-by-cycle vector table plus hand
// sequences for read timeout/late response and mid-transfer reset.
module tb_ahb_bridge_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hready;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic [40:0] packet;
  logic        hvalid;
  logic        brdy;
  logic [31:0] rdata;
  logic        rdv;
  logic        late;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_bridge_ctrl #(.ADDR_LSB(2), .TIMEOUT(16), .CNT_W(8)) dut (
    .HCLK(clk), .RESETn(rst_n), .HSEL(hsel), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HADDR(haddr), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .Packet_IN(packet),
    .H_Valid(hvalid), .Bridge_Ready(brdy), .Bridge_Rd_Data(rdata),
    .Bridge_Rd_Valid(rdv), .late_rsp(late)
  );

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        brdy;
    logic        rdv;
    logic [31:0] rdata;
    logic        e_rdy;
    logic        e_resp;
    logic        e_hv;
    logic [40:0] e_pkt;
    logic [31:0] e_hrdata;
    logic        e_late;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic s, input logic [1:0] t, input logic w,
                              input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              input logic br, input logic rv, input logic [31:0] rd,
                              input logic e_rdy, input logic e_resp, input logic e_hv,
                              input logic [40:0] e_pkt, input logic [31:0] e_hrdata,
                              input logic e_late);
    vec_t v;
    v.hsel = s; v.htrans = t; v.hwrite = w; v.hsize = sz; v.haddr = a; v.hwdata = wd;
    v.brdy = br; v.rdv = rv; v.rdata = rd;
    v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_hv = e_hv; v.e_pkt = e_pkt;
    v.e_hrdata = e_hrdata; v.e_late = e_late;
    vq.push_back(v);
  endfunction

  task automatic drive(input logic s, input logic [1:0] t, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic br,
                       input logic rv, input logic [31:0] rd);
    hsel = s; htrans = t; hwrite = w; hsize = sz; haddr = a; hwdata = wd;
    brdy = br; rdv = rv; rdata = rd;
  endtask

  task automatic check(input string name, input logic e_rdy, input logic e_resp,
                       input logic e_hv, input logic [40:0] e_pkt, input logic [31:0] e_hrdata,
                       input logic e_late);
    logic [107:0] got, exp;
    got = {hreadyout, hresp, hvalid, packet, hrdata, late};
    exp = {e_rdy, e_resp, e_hv, e_pkt, e_hrdata, e_late};
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got rdy=%b resp=%b hv=%b pkt=%h rd=%h late=%b, want rdy=%b resp=%b hv=%b pkt=%h rd=%h late=%b",
               name, hreadyout, hresp, hvalid, packet, hrdata, late,
               e_rdy, e_resp, e_hv, e_pkt, e_hrdata, e_late);
    end
  endtask

  // Apply inputs after a posedge, check at the negedge, then advance.
  task automatic step_chk(input string name, input logic e_rdy, input logic e_resp,
                          input logic e_hv, input logic [40:0] e_pkt,
                          input logic [31:0] e_hrdata, input logic e_late);
    @(negedge clk);
    check(name, e_rdy, e_resp, e_hv, e_pkt, e_hrdata, e_late);
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [2:0] W32 = 3'b010;
  localparam logic [40:0] Z = 41'h0;

  initial begin
    rst_n = 1'b0;
    drive(0, ID, 0, W32, 0, 0, 0, 0, 0);

    // Test 1: write 0x104, zero wait
    add(1, NS, 1, W32, 32'h104, 0,            1, 0, 0, 1, 0, 0, Z, 0, 0);
    add(0, ID, 0, W32, 0, 32'hDEADBEEF,       1, 0, 0, 1, 0, 1, 41'h1_41_DEADBEEF, 0, 0);
    // Test 2: same write with 3 cycles of backpressure
    add(1, NS, 1, W32, 32'h104, 0,            1, 0, 0, 1, 0, 0, Z, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, ID, 0, W32, 0, 32'hDEADBEEF,     0, 0, 0, 0, 0, 0, 41'h1_41_DEADBEEF, 0, 0);
    add(0, ID, 0, W32, 0, 32'hDEADBEEF,       1, 0, 0, 1, 0, 1, 41'h1_41_DEADBEEF, 0, 0);
    // Test 3: read 0x008, response after 5 cycles
    add(1, NS, 0, W32, 32'h008, 0,            1, 0, 0, 1, 0, 0, Z, 0, 0);
    add(0, ID, 0, W32, 0, 0,                  0, 0, 0, 0, 0, 0, 41'h0_02_00000000, 0, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 0, 0, 0, 0, 1, 41'h0_02_00000000, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, ID, 0, W32, 0, 0,                1, 0, 0, 0, 0, 0, Z, 0, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 1, 32'hCAFEF00D, 0, 0, 0, Z, 0, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 0, 0, 1, 0, 0, Z, 32'hCAFEF00D, 0);
    // Test 5: write pipelined with an illegal-size read
    add(1, NS, 1, W32, 32'h200, 0,            1, 0, 0, 1, 0, 0, Z, 32'hCAFEF00D, 0);
    add(1, NS, 0, 3'b001, 32'h00C, 32'h12345678, 1, 0, 0, 1, 0, 1, 41'h1_80_12345678, 32'hCAFEF00D, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 0, 0, 0, 1, 0, Z, 32'hCAFEF00D, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 0, 0, 1, 1, 0, Z, 32'hCAFEF00D, 0);
    // Read with immediate response, then a write pipelined into RD_DONE
    add(1, NS, 0, W32, 32'h3FC, 0,            1, 0, 0, 1, 0, 0, Z, 32'hCAFEF00D, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 0, 0, 0, 0, 1, 41'h0_FF_00000000, 32'hCAFEF00D, 0);
    add(0, ID, 0, W32, 0, 0,                  1, 1, 32'h0BADF00D, 0, 0, 0, Z, 32'hCAFEF00D, 0);
    add(1, NS, 1, W32, 32'h004, 0,            1, 0, 0, 1, 0, 0, Z, 32'h0BADF00D, 0);
    add(0, ID, 0, W32, 0, 32'hA5A5A5A5,       1, 0, 0, 1, 0, 1, 41'h1_01_A5A5A5A5, 32'h0BADF00D, 0);
    // BUSY and unselected NONSEQ: no action, zero-wait OKAY
    add(1, 2'b01, 1, W32, 32'h010, 0,         1, 0, 0, 1, 0, 0, Z, 32'h0BADF00D, 0);
    add(0, NS, 1, W32, 32'h010, 0,            1, 0, 0, 1, 0, 0, Z, 32'h0BADF00D, 0);
    add(0, ID, 0, W32, 0, 32'hFFFFFFFF,       1, 0, 0, 1, 0, 0, Z, 32'h0BADF00D, 0);

    #12;
    @(negedge clk);
    check("reset_state", 1, 0, 0, Z, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vq[i]) begin
      drive(vq[i].hsel, vq[i].htrans, vq[i].hwrite, vq[i].hsize, vq[i].haddr,
            vq[i].hwdata, vq[i].brdy, vq[i].rdv, vq[i].rdata);
      step_chk($sformatf("vec%0d", i), vq[i].e_rdy, vq[i].e_resp, vq[i].e_hv,
               vq[i].e_pkt, vq[i].e_hrdata, vq[i].e_late);
    end

    // Test 4: read timeout after 16 RD_WAIT cycles, then a late response
    drive(1, NS, 0, W32, 32'h010, 0, 1, 0, 0);
    step_chk("to_addr", 1, 0, 0, Z, 32'h0BADF00D, 0);
    drive(0, ID, 0, W32, 0, 0, 1, 0, 0);
    step_chk("to_req", 0, 0, 1, 41'h0_04_00000000, 32'h0BADF00D, 0);
    for (int i = 0; i < 16; i++)
      step_chk($sformatf("to_wait%0d", i), 0, 0, 0, Z, 32'h0BADF00D, 0);
    step_chk("to_err1", 0, 1, 0, Z, 32'h0BADF00D, 0);
    step_chk("to_err2", 1, 1, 0, Z, 32'h0BADF00D, 0);
    drive(0, ID, 0, W32, 0, 0, 1, 1, 32'h77777777);
    step_chk("late_idle", 1, 0, 0, Z, 32'h0BADF00D, 0);
    drive(0, ID, 0, W32, 0, 0, 1, 0, 0);
    step_chk("late_set", 1, 0, 0, Z, 32'h0BADF00D, 1);

    // Test 6: reset asserted mid-RD_WAIT takes effect before the next edge
    drive(1, NS, 0, W32, 32'h020, 0, 1, 0, 0);
    step_chk("rst_addr", 1, 0, 0, Z, 32'h0BADF00D, 1);
    drive(0, ID, 0, W32, 0, 0, 1, 0, 0);
    step_chk("rst_req", 0, 0, 1, 41'h0_08_00000000, 32'h0BADF00D, 1);
    step_chk("rst_wait", 0, 0, 0, Z, 32'h0BADF00D, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 1, 0, 0, Z, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, NS, 1, W32, 32'h00C, 0, 1, 0, 0);
    step_chk("post_rst_addr", 1, 0, 0, Z, 0, 0);
    drive(0, ID, 0, W32, 0, 32'h5A5A0001, 1, 0, 0);
    step_chk("post_rst_wr", 1, 0, 1, 41'h1_03_5A5A0001, 0, 0);
    step_chk("post_rst_idle", 1, 0, 0, Z, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
